// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with a generic operand width,
// a per-operation signed/unsigned mode and a start/busy/done handshake.
// Operands are widened by one bit (sign- or zero-extended), so a single Booth
// datapath is correct in both modes.
module booth_mult_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               done
);

    localparam int E = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(E - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [E-1:0]     a;
    logic [E-1:0]     m;
    logic [E-1:0]     q;
    logic             q_1;
    logic [CNT_W-1:0] count;

    logic [E-1:0]     mc_x;
    logic [E-1:0]     mp_x;
    logic [E-1:0]     a_n;

    // Extend incoming operands to E bits according to the requested mode
    always_comb begin
        mc_x = sgn ? {mc[WIDTH-1], mc} : {1'b0, mc};
        mp_x = sgn ? {mp[WIDTH-1], mp} : {1'b0, mp};
    end

    // Booth add/subtract decision for the current step (carry-out discarded)
    always_comb begin
        a_n = a;
        case ({q[0], q_1})
            2'b01:   a_n = a + m;
            2'b10:   a_n = a + (~m) + E'(1);
            default: a_n = a;
        endcase
    end

    // Control FSM and datapath registers: accept, iterate, shift, complete
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= mc_x;
                        q     <= mp_x;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a     <= {a_n[E-1], a_n[E-1:1]};
                    q     <= {a_n[0], q[E-1:1]};
                    q_1   <= q[0];
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        // Low 2*WIDTH bits of the post-shift {A,Q}, taken straight
                        // from the pre-shift values so prod lands on this edge.
                        prod  <= {a_n[E-2:0], q[E-1:1]};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=4 and a WIDTH=8 instance sharing one clock.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, sgn4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  prod4;
    logic        start8, sgn8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] prod8;

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .mc(mc4), .mp(mp4),
        .prod(prod4), .busy(busy4), .done(done4)
    );

    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .mc(mc8), .mp(mp8),
        .prod(prod8), .busy(busy8), .done(done8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic [15:0] get_prod(input bit w8);
        return w8 ? prod8 : {8'h00, prod4};
    endfunction

    // One complete operation: latency, busy width, single done pulse, result,
    // and the old product still visible mid-run. Operands are scrambled during RUN.
    task automatic run_op(input bit w8, input bit s, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input logic [15:0] prev, input string tag);
        int lat;
        int busy_n;
        int done_n;
        int done_at;
        lat = w8 ? 9 : 5;
        busy_n = 0;
        done_n = 0;
        done_at = -1;
        if (w8) begin
            start8 = 1'b1; sgn8 = s; mc8 = a; mp8 = b;
        end else begin
            start4 = 1'b1; sgn4 = s; mc4 = a[3:0]; mp4 = b[3:0];
        end
        tick;
        start4 = 1'b0; start8 = 1'b0;
        sgn4 = ~sgn4; mc4 = ~mc4; mp4 = mp4 + 4'd3;
        sgn8 = ~sgn8; mc8 = ~mc8; mp8 = mp8 + 8'd3;
        if (get_busy(w8)) busy_n++;
        check({tag, ".busy_on"}, 32'(get_busy(w8)), 32'd1);
        for (int k = 1; k <= lat + 3; k++) begin
            tick;
            if (get_busy(w8)) busy_n++;
            if (k == 2) check({tag, ".prev_held"}, 32'(get_prod(w8)), 32'(prev));
            if (get_done(w8)) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    check({tag, ".prod"}, 32'(get_prod(w8)), 32'(exp));
                end
            end
        end
        check({tag, ".latency"}, 32'(done_at), 32'(lat));
        check({tag, ".done_cnt"}, 32'(done_n), 32'd1);
        check({tag, ".busy_cyc"}, 32'(busy_n), 32'(lat));
        check({tag, ".prod_hold"}, 32'(get_prod(w8)), 32'(exp));
    endtask

    initial begin
        int done_n;
        int done_at;
        int d1;
        int d2;

        rst = 1'b1;
        start4 = 1'b0; sgn4 = 1'b0; mc4 = '0; mp4 = '0;
        start8 = 1'b0; sgn8 = 1'b0; mc8 = '0; mp8 = '0;
        tick;
        tick;
        check("rst.prod4", 32'(prod4), 32'd0);
        check("rst.busy4", 32'(busy4), 32'd0);
        check("rst.done4", 32'(done4), 32'd0);
        check("rst.prod8", 32'(prod8), 32'd0);
        // reset overrides start
        start4 = 1'b1; mc4 = 4'h3; mp4 = 4'h3;
        tick;
        check("rst.over_start", 32'(busy4), 32'd0);
        start4 = 1'b0;
        rst = 1'b0;
        tick;

        run_op(1'b0, 1'b1, 8'h08, 8'h08, 16'h0040, 16'h0000, "s4_min_min");
        run_op(1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 16'h0040, "u4_max_max");
        run_op(1'b0, 1'b1, 8'h0F, 8'h0F, 16'h0001, 16'h00E1, "s4_m1_m1");
        run_op(1'b0, 1'b1, 8'h07, 8'h0D, 16'h00EB, 16'h0001, "s4_7_m3");
        run_op(1'b0, 1'b1, 8'h00, 8'h09, 16'h0000, 16'h00EB, "s4_0_m7");
        run_op(1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080, 16'h0000, "s8_m128_127");
        run_op(1'b1, 1'b0, 8'h80, 8'h7F, 16'h3F80, 16'hC080, "u8_128_127");

        // start re-pulsed on cycle 2 of RUN must be ignored
        start4 = 1'b1; sgn4 = 1'b0; mc4 = 4'd3; mp4 = 4'd5;
        tick;
        start4 = 1'b0;
        tick;
        start4 = 1'b1; mc4 = 4'd2; mp4 = 4'd2;
        tick;
        start4 = 1'b0;
        done_n = 0;
        done_at = -1;
        for (int k = 3; k <= 14; k++) begin
            tick;
            if (done4) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
        end
        check("restart.done_cnt", 32'(done_n), 32'd1);
        check("restart.latency", 32'(done_at), 32'd5);
        check("restart.prod", 32'(prod4), 32'h0F);
        check("restart.idle", 32'(busy4), 32'd0);

        // start held high: back-to-back operations six cycles apart
        start4 = 1'b1; sgn4 = 1'b0; mc4 = 4'd3; mp4 = 4'd5;
        d1 = -1;
        d2 = -1;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (done4) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start4 = 1'b0;
        check("held.first_done", 32'(d1), 32'd5);
        check("held.interval", 32'(d2 - d1), 32'd6);
        for (int k = 0; k < 12 && busy4; k++) tick;
        check("held.drained", 32'(busy4), 32'd0);
        check("held.prod", 32'(prod4), 32'h0F);
        tick;

        // reset on cycle 3 of RUN aborts the operation
        start4 = 1'b1; sgn4 = 1'b0; mc4 = 4'd7; mp4 = 4'd7;
        tick;
        start4 = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort.prod", 32'(prod4), 32'd0);
        check("abort.busy", 32'(busy4), 32'd0);
        check("abort.done", 32'(done4), 32'd0);
        done_n = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (done4) done_n++;
        end
        check("abort.no_done", 32'(done_n), 32'd0);
        run_op(1'b0, 1'b0, 8'h02, 8'h03, 16'h0006, 16'h0000, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
